// File: rtl/chroma_upsample_stream.sv
// chroma_upsample_stream: buffers an NxN chroma block, then streams it 2x upsampled (4:2:0 or 4:2:2, bilinear or replicate)
module chroma_upsample_stream #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*W-1:0]         in_row,
    input  logic                   mode_v2,
    input  logic                   mode_bilinear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N*W-1:0]       out_row,
    output logic [$clog2(2*N)-1:0] out_row_idx,
    output logic                   out_last
);
    localparam int CW = $clog2(N);
    localparam int IW = $clog2(2*N);
    localparam int SW = W + 5;

    typedef enum logic {LOAD, EMIT} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_rcnt;
    logic             r_v2;
    logic             r_bil;
    logic [N*W-1:0]   r_buf [N];
    logic [IW-1:0]    w_nidx;
    logic [IW-1:0]    w_rlast;
    logic [N*W-1:0]   w_ra;
    logic [N*W-1:0]   w_rb;
    logic [2*N*W-1:0] w_row;
    logic             w_in_hs;
    logic             w_out_hs;

    assign in_ready = (r_state == LOAD);
    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = out_valid && out_ready;
    assign w_rlast  = r_v2 ? IW'(2*N-1) : IW'(N-1);
    // The row being prepared is row 0 while loading, otherwise the one after the current row
    assign w_nidx   = (r_state == LOAD) ? '0 : out_row_idx + IW'(1);

    // Select the nearest and the neighbouring source rows of the next output row, clamped at the block edges
    always_comb begin
        int r;
        int ri;
        int rn;
        r = int'(w_nidx);
        ri = r_v2 ? r / 2 : r;
        rn = !r_v2 ? ri : (r[0] ? ri + 1 : ri - 1);
        rn = (rn < 0) ? 0 : (rn > N-1) ? N-1 : rn;
        w_ra = '0;
        w_rb = '0;
        for (int k = 0; k < N; k++) begin
            if (k == ri) w_ra = r_buf[k[CW-1:0]];
            if (k == rn) w_rb = r_buf[k[CW-1:0]];
        end
    end

    // Horizontal neighbours are fixed per output column. Without vertical scaling both rows are the same,
    // so the 9/3/3/1 kernel collapses exactly to (3a+b+2)>>2 and one datapath serves both modes.
    for (genvar c = 0; c < 2*N; c++) begin : g_col
        localparam int CI  = c / 2;
        localparam int CN0 = (c % 2 == 0) ? CI - 1 : CI + 1;
        localparam int CN  = (CN0 < 0) ? 0 : (CN0 > N-1) ? N-1 : CN0;
        logic [SW-1:0] w_s;
        assign w_s = SW'(9) * SW'(w_ra[CI*W +: W]) + SW'(3) * SW'(w_ra[CN*W +: W])
                   + SW'(3) * SW'(w_rb[CI*W +: W]) + SW'(w_rb[CN*W +: W]) + SW'(8);
        assign w_row[c*W +: W] = r_bil ? w_s[W+3:4] : w_ra[CI*W +: W];
    end

    // Store each accepted input row; buffer contents need no reset
    always_ff @(posedge clk) begin
        if (w_in_hs) r_buf[r_rcnt] <= in_row;
    end

    // LOAD/EMIT sequencing with registered output rows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOAD;
            r_rcnt      <= '0;
            r_v2        <= 1'b0;
            r_bil       <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_row     <= '0;
            out_row_idx <= '0;
        end else if (r_state == LOAD) begin
            if (w_in_hs) begin
                if (r_rcnt == '0) begin
                    r_v2  <= mode_v2;
                    r_bil <= mode_bilinear;
                end
                if (r_rcnt == CW'(N-1)) begin
                    r_state     <= EMIT;
                    r_rcnt      <= '0;
                    out_valid   <= 1'b1;
                    out_row     <= w_row;
                    out_row_idx <= '0;
                    out_last    <= 1'b0;
                end else begin
                    r_rcnt <= r_rcnt + CW'(1);
                end
            end
        end else if (w_out_hs) begin
            if (out_last) begin
                r_state     <= LOAD;
                out_valid   <= 1'b0;
                out_last    <= 1'b0;
                out_row_idx <= '0;
            end else begin
                out_row     <= w_row;
                out_row_idx <= w_nidx;
                out_last    <= (w_nidx == w_rlast);
            end
        end
    end
endmodule

// File: tb/tb_chroma_upsample_stream.sv
// tb_chroma_upsample_stream: directed checks of the chroma upsampler
module tb_chroma_upsample_stream;
    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N*W-1:0]   in_row = '0;
    logic             mode_v2 = 1'b0;
    logic             mode_bilinear = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*N*W-1:0] out_row;
    logic [2:0]       out_row_idx;
    logic             out_last;

    logic [7:0]  img [4][4];
    logic [63:0] got_rows [8];
    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    chroma_upsample_stream #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .mode_v2(mode_v2), .mode_bilinear(mode_bilinear),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int clampi(int v);
        return (v < 0) ? 0 : (v > N-1) ? N-1 : v;
    endfunction

    function automatic logic [7:0] model(int r, int c, bit v2, bit bil);
        int ri, rn, ci, cn, a, b, p, q;
        ci = c / 2;
        cn = clampi((c % 2 == 0) ? ci - 1 : ci + 1);
        ri = v2 ? r / 2 : r;
        rn = v2 ? clampi((r % 2 == 0) ? ri - 1 : ri + 1) : ri;
        a = int'(img[ri][ci]);
        b = int'(img[ri][cn]);
        p = int'(img[rn][ci]);
        q = int'(img[rn][cn]);
        if (!bil) return img[ri][ci];
        if (v2) return 8'((9*a + 3*b + 3*p + q + 8) >> 4);
        return 8'((3*a + b + 2) >> 2);
    endfunction

    function automatic logic [63:0] exp_row(int r, bit v2, bit bil);
        logic [63:0] v;
        for (int c = 0; c < 2*N; c++) v[c*8 +: 8] = model(r, c, v2, bil);
        return v;
    endfunction

    function automatic logic [N*W-1:0] pack(int i);
        logic [N*W-1:0] v;
        for (int j = 0; j < N; j++) v[j*W +: W] = img[i][j];
        return v;
    endfunction

    task automatic set_ramp();
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) img[i][j] = 8'(4*i + j);
    endtask

    task automatic set_const(input logic [7:0] v);
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) img[i][j] = v;
    endtask

    task automatic set_mix(input int seed);
        for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) img[i][j] = 8'(37*i + 91*j + seed);
    endtask

    // Mode inputs are inverted on rows 1..N-1 so a block only follows row 0's modes
    task automatic send_block(input bit v2, input bit bil, input bit gap, input int nrows);
        check("load_rdy", in_ready, 1);
        for (int i = 0; i < nrows; i++) begin
            if (gap && i == 2) begin
                in_valid = 1'b0;
                in_row = 32'hDEADBEEF;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_row = pack(i);
            mode_v2 = (i == 0) ? v2 : !v2;
            mode_bilinear = (i == 0) ? bil : !bil;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        mode_v2 = !v2;
        mode_bilinear = !bil;
    endtask

    task automatic recv_block(input bit v2, input bit bil, input bit rnd, input bit junk, output int ncyc);
        int R, row;
        logic [63:0] held;
        bit stalled;
        R = v2 ? 8 : 4;
        row = 0;
        ncyc = 0;
        stalled = 1'b0;
        held = '0;
        while (row < R && ncyc < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk) begin
                in_valid = 1'b1;
                in_row = $urandom;
            end
            @(negedge clk);
            if (stalled) begin
                check("hold_row", out_row, held);
                check("hold_idx", out_row_idx, row);
            end
            check("emit_rdy", in_ready, 0);
            check("emit_valid", out_valid, 1);
            stalled = !out_ready;
            held = out_row;
            if (out_valid && out_ready) begin
                check("idx", out_row_idx, row);
                check("last", out_last, row == R-1);
                check($sformatf("row%0d", row), out_row, exp_row(row, v2, bil));
                got_rows[row] = out_row;
                row++;
            end
            @(posedge clk); #1;
            ncyc++;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("rows_done", row, R);
        check("idle_valid", out_valid, 0);
        check("idle_rdy", in_ready, 1);
    endtask

    task automatic check_first_row();
        check("lat_valid", out_valid, 1);
        check("lat_idx", out_row_idx, 0);
        check("lat_last", out_last, 0);
        check("lat_rdy", in_ready, 0);
    endtask

    initial begin
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_row", out_row, 0);
        check("rst_idx", out_row_idx, 0);
        check("rst_last", out_last, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rdy", in_ready, 1);
        @(posedge clk); #1;

        set_ramp();
        send_block(1, 1, 0, N);
        check_first_row();
        recv_block(1, 1, 0, 0, cyc);
        check("v2_cycles", cyc, 8);
        check("out00", got_rows[0][7:0], 8'd0);
        check("out11", got_rows[1][15:8], 8'd1);
        check("out23", got_rows[2][31:24], 8'd4);
        check("out77", got_rows[7][63:56], 8'd15);

        send_block(0, 1, 0, N);
        check_first_row();
        recv_block(0, 1, 0, 0, cyc);
        check("h_cycles", cyc, 4);
        check("h_row0", got_rows[0], 64'h0303020201010000);

        send_block(1, 0, 1, N);
        check_first_row();
        recv_block(1, 0, 0, 0, cyc);
        check("rep56", got_rows[5][55:48], 8'd11);

        set_const(8'hFF);
        send_block(1, 1, 0, N);
        recv_block(1, 1, 0, 0, cyc);
        for (int r = 0; r < 8; r++) check("all255", got_rows[r], 64'hFFFF_FFFF_FFFF_FFFF);

        set_const(8'h00);
        send_block(1, 1, 0, N);
        recv_block(1, 1, 0, 0, cyc);
        for (int r = 0; r < 8; r++) check("all0", got_rows[r], 64'h0);

        set_mix(13);
        send_block(1, 1, 0, N);
        recv_block(1, 1, 1, 1, cyc);
        set_mix(200);
        send_block(0, 0, 1, N);
        recv_block(0, 0, 1, 1, cyc);

        set_ramp();
        send_block(1, 1, 0, 2);
        rst = 1'b1;
        #1;
        check("mid_load_valid", out_valid, 0);
        check("mid_load_rdy", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_rdy", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        set_mix(77);
        send_block(1, 1, 0, N);
        check_first_row();
        recv_block(1, 1, 0, 0, cyc);

        set_ramp();
        send_block(1, 1, 0, N);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("mid_emit_idx1", out_row_idx, 1);
        rst = 1'b1;
        #1;
        check("mid_emit_valid", out_valid, 0);
        check("mid_emit_idx", out_row_idx, 0);
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("emit_rst_rdy", in_ready, 1);
        send_block(0, 1, 0, N);
        recv_block(0, 1, 1, 0, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
